// File: rtl/ex_muldiv_ctrl_if.sv
// rtl/ex_muldiv_ctrl_if.sv - EX-stage mul/div request and result bundle
interface ex_muldiv_ctrl_if #(
    parameter int XLEN = 32
);
    logic            start_ex;
    logic [1:0]      MulDivOp_ex;
    logic [XLEN-1:0] opA_ex;
    logic [XLEN-1:0] opB_ex;
    logic            flush;
    logic            stall;
    logic            busy;
    logic            result_valid;
    logic [XLEN-1:0] MulDivResult_ex;

    modport master (
        output start_ex, MulDivOp_ex, opA_ex, opB_ex, flush,
        input  stall, busy, result_valid, MulDivResult_ex
    );

    modport slave (
        input  start_ex, MulDivOp_ex, opA_ex, opB_ex, flush,
        output stall, busy, result_valid, MulDivResult_ex
    );
endinterface

// File: rtl/ex_muldiv_ctrl.sv
// rtl/ex_muldiv_ctrl.sv - iterative unsigned mul/div unit that stalls the EX stage
module ex_muldiv_ctrl #(
    parameter int XLEN = 32
) (
    input  logic           clk,
    input  logic           reset,
    ex_muldiv_ctrl_if.slave io
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [5:0] LAST_ITER = 6'(XLEN - 1);

    logic [1:0]        state;
    logic [5:0]        iter_cnt;
    logic [1:0]        op_q;
    logic [XLEN-1:0]   opb_q;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   result_q;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_trial;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] acc_next;

    // Both operations keep the running high word in acc[63:32] and the
    // multiplier / dividend-turned-quotient in acc[31:0], so one register serves both.
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb_q} : '0);
        mul_next  = {mul_sum, acc[XLEN-1:1]};
        div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_trial = div_shift - {1'b0, opb_q};
        div_next  = div_trial[XLEN] ? {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                    : {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        acc_next  = op_q[1] ? div_next : mul_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            iter_cnt <= '0;
            op_q     <= '0;
            opb_q    <= '0;
            acc      <= '0;
            result_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (io.start_ex && !io.flush) begin
                        op_q     <= io.MulDivOp_ex;
                        opb_q    <= io.opB_ex;
                        acc      <= {{XLEN{1'b0}}, io.opA_ex};
                        iter_cnt <= '0;
                        state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (io.flush) begin
                        state <= S_IDLE;
                    end else begin
                        acc      <= acc_next;
                        iter_cnt <= iter_cnt + 6'd1;
                        if (iter_cnt == LAST_ITER) begin
                            // MUL/DIVU take the low word, MULHU/REMU the high word.
                            result_q <= op_q[0] ? acc_next[2*XLEN-1:XLEN] : acc_next[XLEN-1:0];
                            state    <= S_DONE;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        io.stall           = !reset && ((state == S_BUSY) ||
                             ((state == S_IDLE) && io.start_ex && !io.flush));
        io.busy            = (state == S_BUSY);
        io.result_valid    = (state == S_DONE) && !io.flush;
        io.MulDivResult_ex = result_q;
    end
endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// tb/tb_ex_muldiv_ctrl.sv - self-checking bench for ex_muldiv_ctrl
module tb_ex_muldiv_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    ex_muldiv_ctrl_if #(.XLEN(32)) io ();

    ex_muldiv_ctrl #(.XLEN(32)) dut (
        .clk  (clk),
        .reset(reset),
        .io   (io)
    );

    function automatic logic [31:0] ref_calc(logic [1:0] op, logic [31:0] a, logic [31:0] b);
        logic [63:0] p;
        p = {32'b0, a} * {32'b0, b};
        case (op)
            2'd0:    return p[31:0];
            2'd1:    return p[63:32];
            2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: an accepted instruction occupies the unit for
    // 32 busy cycles and presents its result in the 33rd cycle after the start.
    bit          m_ready = 0;
    bit          m_active = 0;
    int          m_age = 0;
    logic [31:0] m_pend = '0;
    logic [31:0] m_last = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_active = 0;
            m_age    = 0;
            m_last   = '0;
            m_ready  = 1;
        end else if (m_ready) begin
            if (m_active) begin
                if (m_age == 33 || io.flush) begin
                    m_active = 0;
                end else begin
                    m_age++;
                    if (m_age == 33) m_last = m_pend;
                end
            end else if (io.start_ex && !io.flush) begin
                m_active = 1;
                m_age    = 1;
                m_pend   = ref_calc(io.MulDivOp_ex, io.opA_ex, io.opB_ex);
            end
        end
    end

    always @(negedge clk) begin
        if (m_ready) begin
            logic in_busy;
            in_busy = m_active && (m_age <= 32);
            check("stall", 32'(io.stall),
                  32'(!reset && (in_busy || (!m_active && io.start_ex && !io.flush))));
            check("busy", 32'(io.busy), 32'(in_busy));
            check("result_valid", 32'(io.result_valid), 32'(m_active && m_age == 33 && !io.flush));
            check("result", io.MulDivResult_ex, m_last);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves start_ex high one cycle past result_valid so callers can chain.
    task automatic run_op(string name, logic [1:0] op, logic [31:0] a, logic [31:0] b,
                          logic [31:0] lit);
        bit          seen = 0;
        int          k = 0;
        int          st = 0;
        logic [31:0] r = '0;
        io.start_ex = 1'b1;
        io.MulDivOp_ex = op;
        io.opA_ex = a;
        io.opB_ex = b;
        for (int i = 0; i < 60 && !seen; i++) begin
            #1;
            if (io.result_valid) begin
                seen = 1;
                k = i;
                r = io.MulDivResult_ex;
                check({name, " stall_at_done"}, 32'(io.stall), 32'd0);
            end else begin
                if (io.stall) st++;
                @(posedge clk);
                #1;
                io.opA_ex = $urandom;
                io.opB_ex = $urandom;
            end
        end
        check({name, " seen"}, 32'(seen), 32'd1);
        check({name, " latency"}, k, 32'd33);
        check({name, " stall_cycles"}, st, 32'd33);
        check({name, " value"}, r, lit);
        tick();
    endtask

    initial begin
        reset = 1'b1;
        io.start_ex = 1'b0;
        io.MulDivOp_ex = 2'd0;
        io.opA_ex = '0;
        io.opB_ex = '0;
        io.flush = 1'b0;
        tick();
        check("rst stall", 32'(io.stall), 32'd0);
        check("rst busy", 32'(io.busy), 32'd0);
        check("rst rv", 32'(io.result_valid), 32'd0);
        check("rst result", io.MulDivResult_ex, 32'd0);
        tick();
        reset = 1'b0;

        run_op("mul7x6", 2'd0, 32'd7, 32'd6, 32'd42);
        io.start_ex = 1'b0;
        tick();
        run_op("mulhu_ff", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        io.start_ex = 1'b0;
        run_op("mul_ff", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        io.start_ex = 1'b0;
        run_op("divu100_7", 2'd2, 32'd100, 32'd7, 32'd14);
        io.start_ex = 1'b0;
        run_op("remu100_7", 2'd3, 32'd100, 32'd7, 32'd2);
        io.start_ex = 1'b0;
        run_op("divu5_0", 2'd2, 32'd5, 32'd0, 32'hFFFF_FFFF);
        io.start_ex = 1'b0;
        run_op("remu5_0", 2'd3, 32'd5, 32'd0, 32'd5);

        // Back-to-back: second instruction starts in the IDLE cycle after DONE.
        run_op("b2b_mul", 2'd0, 32'd3, 32'd5, 32'd15);
        run_op("b2b_div", 2'd2, 32'd9, 32'd2, 32'd4);
        io.start_ex = 1'b0;
        tick();

        // Flush mid-divide.
        begin
            int rv_seen = 0;
            io.start_ex = 1'b1;
            io.MulDivOp_ex = 2'd2;
            io.opA_ex = 32'd1000;
            io.opB_ex = 32'd3;
            for (int i = 0; i < 10; i++) tick();
            io.flush = 1'b1;
            tick();
            io.flush = 1'b0;
            io.start_ex = 1'b0;
            #1;
            check("flush stall", 32'(io.stall), 32'd0);
            check("flush busy", 32'(io.busy), 32'd0);
            for (int i = 0; i < 40; i++) begin
                if (io.result_valid) rv_seen++;
                tick();
            end
            check("flush no_rv", rv_seen, 32'd0);
            check("flush result_kept", io.MulDivResult_ex, 32'd4);
        end

        // Reset mid-busy.
        io.start_ex = 1'b1;
        io.MulDivOp_ex = 2'd0;
        io.opA_ex = 32'd9;
        io.opB_ex = 32'd9;
        for (int i = 0; i < 21; i++) tick();
        reset = 1'b1;
        io.start_ex = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        check("midrst stall", 32'(io.stall), 32'd0);
        check("midrst busy", 32'(io.busy), 32'd0);
        check("midrst rv", 32'(io.result_valid), 32'd0);
        check("midrst result", io.MulDivResult_ex, 32'd0);
        tick();
        run_op("post_rst_mul", 2'd0, 32'd2, 32'd2, 32'd4);
        io.start_ex = 1'b0;
        tick();

        // Random traffic, with occasional flushes and divisor-zero / small operands.
        for (int n = 0; n < 30; n++) begin
            int flush_at;
            flush_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 36)) : -1;
            io.start_ex = 1'b1;
            io.MulDivOp_ex = 2'($urandom_range(0, 3));
            io.opA_ex = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
            case ($urandom_range(0, 3))
                0:       io.opB_ex = 32'd0;
                1:       io.opB_ex = 32'($urandom_range(1, 20));
                default: io.opB_ex = $urandom;
            endcase
            for (int k = 0; k < 35; k++) begin
                io.flush = (k == flush_at);
                tick();
                io.flush = 1'b0;
                io.opA_ex = $urandom;
                io.opB_ex = $urandom;
            end
            io.start_ex = 1'b0;
            io.flush = ($urandom_range(0, 3) == 0);
            tick();
            io.flush = 1'b0;
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) tick();
        end

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ex_muldiv_ctrl.md
EX_MULDIV_CTRL -- requirements
Module: ex_muldiv_ctrl

Interface
REQ-001 Parameter: XLEN, 32, operand/result width; only 32 is supported.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start_ex  input  1  mul/div instruction present in EX; held high until the instruction leaves EX.
REQ-005 Port: MulDivOp_ex  input  2  00 MUL (low 32 bits), 01 MULHU (high 32 bits), 10 DIVU, 11 REMU; all unsigned.
REQ-006 Port: opA_ex  input  32  forwarded first operand (ALU_A path).
REQ-007 Port: opB_ex  input  32  forwarded second operand (ALU_B path).
REQ-008 Port: flush  input  1  kill the instruction in EX; abort any operation.
REQ-009 Port: stall  output  1  freezes PC, IF/ID and ID/EX; inserts a bubble into EX/MEM.
REQ-010 Port: busy  output  1  high in states START_WAIT-free BUSY only.
REQ-011 Port: result_valid  output  1  one-cycle strobe; MulDivResult_ex is final.
REQ-012 Port: MulDivResult_ex  output  32  product or quotient/remainder selected by the latched op.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-014 In IDLE with start_ex=1 and flush=0, the block SHALL latch opA_ex, opB_ex and MulDivOp_ex, clear the 6-bit iteration counter, and move to BUSY.
REQ-015 stall SHALL be combinational: 1 when (IDLE and start_ex and not flush) or BUSY; 0 in DONE.
REQ-016 BUSY SHALL last exactly 32 cycles, with one iteration per cycle, and the counter incrementing from 0 to 31.
REQ-017 Multiply SHALL use radix-2 shift-add over a 64-bit accumulator: add the multiplicand if the current multiplier LSB is 1, then shift right.
REQ-018 Divide SHALL use restoring division with a 33-bit partial remainder: shift in the dividend MSB, trial-subtract the divisor, and set the quotient bit if the result is non-negative.
REQ-019 When the counter reaches 31, the FSM SHALL move to DONE.
REQ-020 In DONE, the block SHALL assert result_valid for one cycle, drive the final result, and move unconditionally to IDLE.
REQ-021 start_ex SHALL be ignored in DONE, because the same instruction is still in EX.
REQ-022 Latency SHALL be 34 cycles from the start cycle to the result_valid cycle inclusive, with stall high for exactly 33 of those cycles.
REQ-023 Back-to-back mul/div instructions SHALL each restart from IDLE, with no overlap.
REQ-024 MulDivResult_ex SHALL hold its last value until the next DONE, and SHALL update only on entry to DONE.
REQ-025 Division by zero SHALL produce quotient 0xFFFFFFFF and remainder equal to the dividend, through the normal 32 iterations with no special path.
REQ-026 flush=1 in BUSY SHALL force IDLE on the next edge; stall drops that next cycle, result_valid is not asserted, and MulDivResult_ex is unchanged.
REQ-027 flush=1 in DONE SHALL suppress result_valid for that cycle, and the FSM SHALL still go to IDLE.
REQ-028 flush=1 in IDLE SHALL block the start, keeping stall=0 and the FSM in IDLE.
REQ-029 A change on opA_ex or opB_ex during BUSY SHALL have no effect, because only latched operands are used.

Reset
REQ-030 On reset=1 at a rising edge, the state SHALL become IDLE, and the counter, operand registers, accumulator and MulDivResult_ex SHALL be cleared to 0.
REQ-031 During reset, stall, busy and result_valid SHALL be 0 from the cycle after the reset edge.
REQ-032 reset SHALL take priority over flush and start_ex.
REQ-033 Reset asserted mid-BUSY SHALL abort the operation with no result_valid.

Verification
REQ-034 MUL with A=7, B=6 (start at cycle 0) -> stall high for cycles 0-32, result_valid and 42 at cycle 33, stall=0 at cycle 33.
REQ-035 MULHU with A=B=0xFFFFFFFF -> 0xFFFFFFFE; MUL with the same operands -> 0x00000001.
REQ-036 DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
REQ-037 DIVU started, flush at cycle 10 -> stall=0 from cycle 11, no result_valid, MulDivResult_ex keeps its previous value, FSM in IDLE.
REQ-038 Back-to-back MUL 3*5 then DIVU 9/2, with start_ex held until each result_valid -> results 15 and 4, result_valid at cycles 33 and 67.
REQ-039 reset at cycle 20 of BUSY, then a new MUL 2*2 -> all outputs 0 after reset, and the MUL completes 4 with normal 34-cycle latency.
